// File: rtl/spi_slave.sv
// SPI slave with a one-word transmit holding register and a receive word output.
// All SPI pins are synchronised into wb_clk_i. All four modes are supported, in either bit order.
module spi_slave #(
  parameter int WIDTH = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             cpol,
  input  logic             cpha,
  input  logic             lsb,
  input  logic             sclk_i,
  input  logic             ss_n_i,
  input  logic             mosi_i,
  output logic             miso_o,
  output logic             miso_oe,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             tx_underrun,
  input  logic             clr_flags
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] tx_shift;
  logic [WIDTH-1:0] rx_shift;
  logic             miso_q;
  logic [WIDTH-1:0] hold_data;
  logic             hold_full;

  logic sclk_s1, sclk_s2, sclk_d;
  logic ss_s1, ss_s2, ss_d;
  logic mosi_s1, mosi_s2;
  logic [1:0] prime;
  logic armed;

  // Two-flop synchronisers plus one edge-detect flop for sclk and ss_n
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sclk_s1 <= cpol;
      sclk_s2 <= cpol;
      sclk_d  <= cpol;
      ss_s1   <= 1'b1;
      ss_s2   <= 1'b1;
      ss_d    <= 1'b1;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      sclk_s1 <= sclk_i;
      sclk_s2 <= sclk_s1;
      sclk_d  <= sclk_s2;
      ss_s1   <= ss_n_i;
      ss_s2   <= ss_s1;
      ss_d    <= ss_s2;
      mosi_s1 <= mosi_i;
      mosi_s2 <= mosi_s1;
    end
  end

  // The synchronisers come out of reset preset to "deselected". If ss_n is
  // still low on release, that preset would look like a falling edge. To avoid
  // this, a frame may only start once ss_n has been seen high on real pin data.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      prime <= 2'b00;
      armed <= 1'b0;
    end else begin
      prime <= {prime[0], 1'b1};
      if (prime[1] && ss_s2)
        armed <= 1'b1;
    end
  end

  logic sclk_edge, lead_edge, trail_edge, sample_edge, shift_edge;
  logic ss_fall, load;

  assign sclk_edge  = sclk_s2 ^ sclk_d;
  assign lead_edge  = sclk_edge & (sclk_s2 != cpol);
  assign trail_edge = sclk_edge & (sclk_s2 == cpol);
  assign ss_fall    = armed & ss_d & ~ss_s2;

  // With cpha=0, the trailing edge that follows the last sample belongs to the word
  // that just finished. The counter is already cleared by the reload, so that edge is skipped.
  assign sample_edge = cpha ? trail_edge : lead_edge;
  assign shift_edge  = cpha ? lead_edge : (trail_edge & (bit_cnt != '0));

  assign load = ((state == IDLE) & ss_fall) | ((state == DONE) & ~ss_s2);

  logic [WIDTH-1:0] load_word, load_next, tx_next, rx_next;
  logic             load_first, tx_first;

  assign load_word  = hold_full ? hold_data : '0;
  assign load_first = lsb ? load_word[0] : load_word[WIDTH-1];
  assign load_next  = lsb ? (load_word >> 1) : (load_word << 1);
  assign tx_first   = lsb ? tx_shift[0] : tx_shift[WIDTH-1];
  assign tx_next    = lsb ? (tx_shift >> 1) : (tx_shift << 1);
  assign rx_next    = lsb ? {mosi_s2, rx_shift[WIDTH-1:1]} : {rx_shift[WIDTH-2:0], mosi_s2};

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (ss_fall) state <= SHIFT;
        SHIFT: begin
          if (ss_s2)
            state <= IDLE;
          else if (sample_edge && bit_cnt == LAST)
            state <= DONE;
        end
        DONE:    state <= ss_s2 ? IDLE : SHIFT;
        default: state <= IDLE;
      endcase
    end
  end

  // With cpha=1, the word is loaded unshifted. The first leading edge then
  // re-presents bit 0 before shifting, so shifting stays uniform for every bit.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      bit_cnt  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      miso_q   <= 1'b0;
    end else if (load) begin
      bit_cnt  <= '0;
      tx_shift <= cpha ? load_word : load_next;
      rx_shift <= '0;
      miso_q   <= load_first;
    end else if (state == SHIFT && !ss_s2) begin
      if (sample_edge) begin
        rx_shift <= rx_next;
        bit_cnt  <= bit_cnt + 1'b1;
      end
      if (shift_edge) begin
        tx_shift <= tx_next;
        miso_q   <= tx_first;
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= (state == DONE);
      if (state == DONE)
        rx_data <= rx_shift;
    end
  end

  // A load empties the holding register. A write in the same cycle still lands,
  // because the write is accepted based on tx_ready from before the clock edge.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      hold_data <= '0;
      hold_full <= 1'b0;
    end else begin
      if (load)
        hold_full <= 1'b0;
      if (tx_valid && !hold_full) begin
        hold_data <= tx_data;
        hold_full <= 1'b1;
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)
      tx_underrun <= 1'b0;
    else if (load && !hold_full)
      tx_underrun <= 1'b1;
    else if (clr_flags)
      tx_underrun <= 1'b0;
  end

  assign tx_ready = ~hold_full;
  assign miso_oe  = (state != IDLE);
  assign miso_o   = miso_oe & miso_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed testbench for spi_slave: it acts as an SPI master with an sclk half-period of
// 8 clocks and checks against hand-computed words.
module tb_spi_slave;

  logic       wb_clk_i = 1'b0;
  logic       wb_rst_i;
  logic       cpol, cpha, lsb;
  logic       sclk_i, ss_n_i, mosi_i;
  logic       miso_o, miso_oe;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, tx_underrun, clr_flags;

  int checks = 0;
  int passes = 0;
  int rx_pulses = 0;

  spi_slave #(.WIDTH(8)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .cpol(cpol), .cpha(cpha), .lsb(lsb),
    .sclk_i(sclk_i), .ss_n_i(ss_n_i), .mosi_i(mosi_i), .miso_o(miso_o), .miso_oe(miso_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .tx_underrun(tx_underrun), .clr_flags(clr_flags)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  always @(negedge wb_clk_i)
    if (rx_valid === 1'b1) rx_pulses++;

  task automatic half_wait;
    repeat (8) @(negedge wb_clk_i);
  endtask

  task automatic set_mode(input logic p, input logic h, input logic l);
    @(negedge wb_clk_i);
    cpol = p; cpha = h; lsb = l; sclk_i = p;
    repeat (10) @(negedge wb_clk_i);
  endtask

  task automatic load_tx(input logic [7:0] w);
    @(negedge wb_clk_i);
    tx_data = w; tx_valid = 1'b1;
    @(negedge wb_clk_i);
    tx_valid = 1'b0;
  endtask

  task automatic pulse_clr;
    @(negedge wb_clk_i); clr_flags = 1'b1;
    @(negedge wb_clk_i); clr_flags = 1'b0;
  endtask

  task automatic ss_begin;
    @(negedge wb_clk_i);
    ss_n_i = 1'b0;
  endtask

  task automatic ss_end;
    half_wait;
    ss_n_i = 1'b1;
    repeat (12) @(negedge wb_clk_i);
  endtask

  // Master side: miso is sampled just before the sclk edge on which the master samples
  task automatic xfer_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    logic [7:0] got;
    int idx;
    got = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      idx = lsb ? i : 7 - i;
      if (!cpha) begin
        mosi_i = mo[idx];
        half_wait;
        got[idx] = miso_o;
        sclk_i = ~cpol;
        half_wait;
        sclk_i = cpol;
      end else begin
        half_wait;
        sclk_i = ~cpol;
        mosi_i = mo[idx];
        half_wait;
        got[idx] = miso_o;
        sclk_i = cpol;
      end
    end
    mi = got;
  endtask

  task automatic frame(input logic [7:0] mo, output logic [7:0] mi);
    ss_begin;
    xfer_bits(mo, 8, mi);
    ss_end;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge wb_clk_i);
    checks++; if (miso_o !== 1'b0) $display("[TB] FAIL reset_miso_o: got %b expected 0", miso_o); else passes++;
    checks++; if (miso_oe !== 1'b0) $display("[TB] FAIL reset_miso_oe: got %b expected 0", miso_oe); else passes++;
    checks++; if (tx_ready !== 1'b1) $display("[TB] FAIL reset_tx_ready: got %b expected 1", tx_ready); else passes++;
    checks++; if (rx_data !== 8'h00) $display("[TB] FAIL reset_rx_data: got %h expected 00", rx_data); else passes++;
    checks++; if (rx_valid !== 1'b0) $display("[TB] FAIL reset_rx_valid: got %b expected 0", rx_valid); else passes++;
    checks++; if (tx_underrun !== 1'b0) $display("[TB] FAIL reset_underrun: got %b expected 0", tx_underrun); else passes++;
    wb_rst_i = 1'b0;
    repeat (6) @(negedge wb_clk_i);
  endtask

  task automatic test_mode0_msb;
    logic [7:0] mi;
    int p0;
    set_mode(1'b0, 1'b0, 1'b0);
    load_tx(8'hA5);
    checks++; if (tx_ready !== 1'b0) $display("[TB] FAIL m0_tx_ready_full: got %b expected 0", tx_ready); else passes++;
    p0 = rx_pulses;
    frame(8'h3C, mi);
    checks++; if (mi !== 8'hA5) $display("[TB] FAIL m0_miso: got %h expected a5", mi); else passes++;
    checks++; if (rx_data !== 8'h3C) $display("[TB] FAIL m0_rx_data: got %h expected 3c", rx_data); else passes++;
    checks++; if (rx_pulses - p0 != 1) $display("[TB] FAIL m0_rx_pulses: got %0d expected 1", rx_pulses - p0); else passes++;
    checks++; if (tx_ready !== 1'b1) $display("[TB] FAIL m0_tx_ready_empty: got %b expected 1", tx_ready); else passes++;
    checks++; if (miso_oe !== 1'b0) $display("[TB] FAIL m0_miso_oe_idle: got %b expected 0", miso_oe); else passes++;
  endtask

  task automatic test_mode3_lsb;
    logic [7:0] mi;
    int p0;
    set_mode(1'b1, 1'b1, 1'b1);
    load_tx(8'h01);
    p0 = rx_pulses;
    frame(8'h80, mi);
    checks++; if (mi[0] !== 1'b1) $display("[TB] FAIL m3_first_bit: got %b expected 1", mi[0]); else passes++;
    checks++; if (mi !== 8'h01) $display("[TB] FAIL m3_miso: got %h expected 01", mi); else passes++;
    checks++; if (rx_data !== 8'h80) $display("[TB] FAIL m3_rx_data: got %h expected 80", rx_data); else passes++;
    checks++; if (rx_pulses - p0 != 1) $display("[TB] FAIL m3_rx_pulses: got %0d expected 1", rx_pulses - p0); else passes++;
  endtask

  task automatic test_underrun;
    logic [7:0] mi;
    set_mode(1'b0, 1'b0, 1'b0);
    pulse_clr;
    checks++; if (tx_underrun !== 1'b0) $display("[TB] FAIL ur_cleared_before: got %b expected 0", tx_underrun); else passes++;
    frame(8'hFF, mi);
    checks++; if (mi !== 8'h00) $display("[TB] FAIL ur_miso: got %h expected 00", mi); else passes++;
    checks++; if (tx_underrun !== 1'b1) $display("[TB] FAIL ur_flag_set: got %b expected 1", tx_underrun); else passes++;
    checks++; if (rx_data !== 8'hFF) $display("[TB] FAIL ur_rx_data: got %h expected ff", rx_data); else passes++;
    pulse_clr;
    checks++; if (tx_underrun !== 1'b0) $display("[TB] FAIL ur_flag_clear: got %b expected 0", tx_underrun); else passes++;
  endtask

  task automatic test_back_to_back;
    logic [7:0] mi1, mi2;
    int p0;
    load_tx(8'h11);
    p0 = rx_pulses;
    ss_begin;
    repeat (4) @(negedge wb_clk_i);
    checks++; if (tx_ready !== 1'b1) $display("[TB] FAIL b2b_tx_ready: got %b expected 1", tx_ready); else passes++;
    load_tx(8'h22);
    xfer_bits(8'h5A, 8, mi1);
    checks++; if (rx_data !== 8'h5A) $display("[TB] FAIL b2b_rx_first: got %h expected 5a", rx_data); else passes++;
    xfer_bits(8'hC3, 8, mi2);
    ss_end;
    checks++; if (mi1 !== 8'h11) $display("[TB] FAIL b2b_miso_first: got %h expected 11", mi1); else passes++;
    checks++; if (mi2 !== 8'h22) $display("[TB] FAIL b2b_miso_second: got %h expected 22", mi2); else passes++;
    checks++; if (rx_data !== 8'hC3) $display("[TB] FAIL b2b_rx_second: got %h expected c3", rx_data); else passes++;
    checks++; if (rx_pulses - p0 != 2) $display("[TB] FAIL b2b_rx_pulses: got %0d expected 2", rx_pulses - p0); else passes++;
  endtask

  task automatic test_abort;
    logic [7:0] mi;
    int p0;
    load_tx(8'h5A);
    p0 = rx_pulses;
    ss_begin;
    xfer_bits(8'h00, 5, mi);
    checks++; if (miso_oe !== 1'b1) $display("[TB] FAIL ab_miso_oe_active: got %b expected 1", miso_oe); else passes++;
    checks++; if ((mi & 8'hF8) !== 8'h58) $display("[TB] FAIL ab_partial_miso: got %h expected 58", mi & 8'hF8); else passes++;
    ss_end;
    checks++; if (miso_oe !== 1'b0) $display("[TB] FAIL ab_miso_oe_off: got %b expected 0", miso_oe); else passes++;
    checks++; if (rx_pulses != p0) $display("[TB] FAIL ab_no_rx_valid: got %0d expected 0", rx_pulses - p0); else passes++;
    load_tx(8'hC3);
    p0 = rx_pulses;
    frame(8'h96, mi);
    checks++; if (mi !== 8'hC3) $display("[TB] FAIL ab_next_miso: got %h expected c3", mi); else passes++;
    checks++; if (rx_data !== 8'h96) $display("[TB] FAIL ab_next_rx: got %h expected 96", rx_data); else passes++;
    checks++; if (rx_pulses - p0 != 1) $display("[TB] FAIL ab_next_pulses: got %0d expected 1", rx_pulses - p0); else passes++;
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] mi;
    int p0;
    load_tx(8'h77);
    ss_begin;
    xfer_bits(8'hAA, 3, mi);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    #1;
    checks++; if (miso_o !== 1'b0) $display("[TB] FAIL rst_mid_miso_o: got %b expected 0", miso_o); else passes++;
    checks++; if (miso_oe !== 1'b0) $display("[TB] FAIL rst_mid_miso_oe: got %b expected 0", miso_oe); else passes++;
    checks++; if (tx_ready !== 1'b1) $display("[TB] FAIL rst_mid_tx_ready: got %b expected 1", tx_ready); else passes++;
    checks++; if (rx_data !== 8'h00) $display("[TB] FAIL rst_mid_rx_data: got %h expected 00", rx_data); else passes++;
    checks++; if (rx_valid !== 1'b0) $display("[TB] FAIL rst_mid_rx_valid: got %b expected 0", rx_valid); else passes++;
    checks++; if (tx_underrun !== 1'b0) $display("[TB] FAIL rst_mid_underrun: got %b expected 0", tx_underrun); else passes++;
    repeat (2) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    p0 = rx_pulses;
    xfer_bits(8'h55, 5, mi);
    checks++; if (miso_oe !== 1'b0) $display("[TB] FAIL rst_no_restart_oe: got %b expected 0", miso_oe); else passes++;
    checks++; if (rx_pulses != p0) $display("[TB] FAIL rst_no_restart_rx: got %0d expected 0", rx_pulses - p0); else passes++;
    ss_end;
    load_tx(8'h3E);
    p0 = rx_pulses;
    frame(8'hE7, mi);
    checks++; if (mi !== 8'h3E) $display("[TB] FAIL rst_after_miso: got %h expected 3e", mi); else passes++;
    checks++; if (rx_data !== 8'hE7) $display("[TB] FAIL rst_after_rx: got %h expected e7", rx_data); else passes++;
    checks++; if (rx_pulses - p0 != 1) $display("[TB] FAIL rst_after_pulses: got %0d expected 1", rx_pulses - p0); else passes++;
  endtask

  initial begin
    wb_rst_i = 1'b1;
    cpol = 1'b0; cpha = 1'b0; lsb = 1'b0;
    sclk_i = 1'b0; ss_n_i = 1'b1; mosi_i = 1'b0;
    tx_data = 8'h00; tx_valid = 1'b0; clr_flags = 1'b0;
    test_reset;
    test_mode0_msb;
    test_mode3_lsb;
    test_underrun;
    test_back_to_back;
    test_abort;
    test_reset_mid_frame;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the frame length in bits and the width of the data ports.
REQ-002 SHALL have port wb_clk_i  input  1  system clock; every flop SHALL be clocked on its rising edge.
REQ-003 SHALL have port wb_rst_i  input  1  reset, asynchronous and active-high; one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port cpol  input  1  SPI clock idle level, static while ss_n_i is low.
REQ-005 SHALL have port cpha  input  1  SPI clock phase: 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-006 SHALL have port lsb  input  1  bit order: 1 = LSB first, 0 = MSB first, applied to both directions.
REQ-007 SHALL have port sclk_i  input  1  SPI clock from the master, asynchronous to wb_clk_i.
REQ-008 SHALL have port ss_n_i  input  1  active-low slave select, asynchronous to wb_clk_i.
REQ-009 SHALL have port mosi_i  input  1  serial data from the master.
REQ-010 SHALL have port miso_o  output  1  serial data to the master.
REQ-011 SHALL have port miso_oe  output  1  output enable for the miso pad driver.
REQ-012 SHALL have port tx_data  input  WIDTH  next word to transmit.
REQ-013 SHALL have port tx_valid  input  1  tx_data is valid.
REQ-014 SHALL have port tx_ready  output  1  transmit holding register is empty.
REQ-015 SHALL have port rx_data  output  WIDTH  last received word.
REQ-016 SHALL have port rx_valid  output  1  one-cycle pulse marking a new rx_data.
REQ-017 SHALL have port tx_underrun  output  1  sticky flag: a frame started with the holding register empty.
REQ-018 SHALL have port clr_flags  input  1  synchronous clear of tx_underrun.

Function
REQ-019 SHALL pass sclk_i, ss_n_i and mosi_i each through a 2-flop synchronizer, then derive rise/fall strobes with one additional flop.
REQ-020 SHALL define the leading edge as the sclk transition away from cpol and the trailing edge as the transition back to cpol.
REQ-021 SHALL act on an sclk edge at the third wb_clk_i rising edge after the pin edge; operation is guaranteed only for an sclk half-period of at least 4 wb_clk_i cycles.
REQ-022 SHALL implement a state machine with states IDLE, SHIFT and DONE.
REQ-023 IDLE -> SHIFT on the synchronized falling edge of ss_n: load the shift register from the holding register (empty holding register: load all zeros and set tx_underrun), clear the bit counter, assert tx_ready.
REQ-024 SHALL accept a write to the holding register (tx_valid & tx_ready) in one cycle; tx_ready then deasserts until the next load.
REQ-025 With cpha=0, SHALL drive the first bit on miso_o on SHIFT entry, sample mosi on each leading edge and shift out on each trailing edge.
REQ-026 With cpha=1, SHALL shift out on each leading edge and sample mosi on each trailing edge.
REQ-027 SHALL increment the bit counter on each sample; when it reaches WIDTH, SHALL go SHIFT -> DONE.
REQ-028 In DONE (one cycle), SHALL update rx_data, pulse rx_valid, and return to SHIFT with a reload per REQ-023 if ss_n is still low, otherwise go to IDLE.
REQ-029 Back-to-back frames SHALL need no sclk gap: with cpha=0, the first bit of the next word SHALL be on miso_o before the next leading edge.
REQ-030 ss_n deasserted in SHIFT SHALL abort the frame: go to IDLE, discard partial rx bits, emit no rx_valid, drop the loaded tx word.
REQ-031 SHALL drive miso_oe = 1 only while not in IDLE; when miso_oe = 0, miso_o = 0.
REQ-032 SHALL ignore sclk edges in IDLE.
REQ-033 If clr_flags and an underrun event coincide, the set SHALL win.

Reset
REQ-034 While wb_rst_i is high, SHALL hold: state IDLE, miso_o 0, miso_oe 0, tx_ready 1, rx_data 0, rx_valid 0, tx_underrun 0, holding register empty, synchronizers at cpol/1/0.
REQ-035 A reset during SHIFT SHALL abort with no rx_valid; after release, SHALL wait for a new ss_n falling edge before starting a frame.

Verification
REQ-036 Mode 0, MSB first: tx 0xA5 loaded, master sends 0x3C -> miso bits 1,0,1,0,0,1,0,1; rx_data 0x3C with a single rx_valid pulse.
REQ-037 Mode 3, LSB first: tx 0x01, master sends 0x80 -> first miso bit 1; rx_data 0x80.
REQ-038 No tx loaded, frame of 0xFF -> miso all 0, tx_underrun 1, rx_data 0xFF; clr_flags -> tx_underrun 0.
REQ-039 Two back-to-back frames under one ss_n low, tx 0x11 then 0x22 -> miso carries 0x11 then 0x22; two rx_valid pulses.
REQ-040 ss_n raised after 5 bits -> no rx_valid, miso_oe 0; the next full frame receives correctly.
REQ-041 wb_rst_i asserted mid-frame -> outputs at REQ-034 values immediately; a subsequent frame completes correctly.
